ahb3lite_mem_slave_p: RTL and testbench
=======================================

# ahb3lite_mem_slave_p

Parametrised AHB-Lite memory slave: the next-generation successor to the single-width CPU/DMA slave. It sits between the AHB-Lite interconnect and a single-port, asynchronous-read memory macro. Compared with the previous slave it adds:
- true address/data-phase pipelining;
- configurable data width;
- per-transfer programmable wait states, with an optional zero-wait path for SEQ beats of a burst;
- HSIZE byte-lane strobes;
- two-cycle ERROR responses for illegal accesses.

## Interface
- DATA_W, 32: data bus width; legal values are 32 and 64.
- ADDR_W, 32: HADDR and mem_addr width.
- MEM_BYTES, 4096: memory size in bytes. Any address at or above MEM_BYTES is illegal.
- WAIT_W, 4: width of cfg_wait_n.
- SEQ_WAIT, 1: selects wait-state handling for SEQ beats.
  - 1: SEQ beats take cfg_wait_n wait states.
  - 0: SEQ beats are zero-wait.
- HCLK  in  1  clock; all logic is on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_W  byte address.
- HTRANS  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3 (ahb3lite_pkg encodings).
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, log2 of bytes.
- HBURST  in  3  burst type; informational only, does not alter behaviour.
- HREADY  in  1  bus-level ready (previous data phase complete).
- HWDATA  in  DATA_W  write data, valid in the data phase.
- HRDATA  out  DATA_W  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  response: 0 = OKAY, 1 = ERROR.
- cfg_wait_n  in  WAIT_W  number of wait states; sampled at address-phase acceptance.
- mem_addr  out  ADDR_W  latched byte address.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable.
- mem_wstrb  out  DATA_W/8  byte-lane write strobes.
- mem_wdata  out  DATA_W  write data to memory.
- mem_rdata  in  DATA_W  memory read data; combinational in mem_addr.

## Operation
- **Acceptance.** An address phase is accepted on a rising edge when HSEL=1, HREADY=1 and HTRANS[1]=1. On acceptance the slave latches HADDR, HWRITE, HSIZE and the wait count.
- **Wait count.** The latched wait count is cfg_wait_n, except that it is 0 when HTRANS=SEQ and SEQ_WAIT=0.
- **IDLE/BUSY.** An IDLE or BUSY transfer, or HSEL=0, produces no data-phase activity: HREADYOUT=1 and HRESP=OKAY.
- **Illegal access.** An accepted transfer is illegal if any of the following holds:
  - HADDR >= MEM_BYTES;
  - 2^HSIZE > DATA_W/8;
  - HADDR is not aligned to 2^HSIZE.
- **State machine:**
  - IDLE: no data phase pending. Goes to WAIT on a legal acceptance with count > 0, DATA on a legal acceptance with count = 0, or ERR1 on an illegal acceptance.
  - WAIT: HREADYOUT=0. The counter decrements each cycle; goes to DATA when the counter reaches 1.
  - DATA: HREADYOUT=1. The memory access occurs this cycle. Next state follows the acceptance rule again (pipelined), or IDLE if nothing is accepted.
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state follows the acceptance rule; a new address may be accepted on this edge.
- **Memory access** occurs only in DATA:
  - mem_rd = ~latched HWRITE.
  - mem_wr = latched HWRITE.
  - mem_wdata = HWDATA.
  - mem_wstrb has 2^HSIZE contiguous ones starting at lane HADDR[log2(DATA_W/8)-1:0].
- **Read data.** HRDATA = mem_rdata in a read DATA cycle, otherwise 0.
- **Outside DATA:** mem_rd=0, mem_wr=0, mem_wstrb=0, mem_wdata=0.
- **No access on error.** No memory strobe is ever asserted for an illegal or IDLE/BUSY transfer.

## Timing
- **Reset values** (HRESET asserted):
  - state = IDLE;
  - HREADYOUT=1, HRESP=0, HRDATA=0;
  - mem_rd=0, mem_wr=0, mem_wstrb=0, mem_wdata=0, mem_addr=0;
  - wait counter = 0.
- **Reset assertion** takes effect immediately, without waiting for HCLK. Any pending transfer is discarded with no memory strobe. Release is synchronised to the next HCLK edge.
- **Latency.** A transfer accepted with wait count N has a data phase of N+1 cycles: HREADYOUT is low for N cycles, then high for 1 cycle.
- **Back-to-back pipelining.** The address phase of transfer k+1 coincides with the final DATA cycle of transfer k. Zero-wait bursts therefore sustain one beat per cycle.
- **mem_addr** updates only on the acceptance edge and holds through WAIT and DATA.
- **Error response.** Always exactly 2 cycles, regardless of cfg_wait_n.
- **HREADY=0 from another slave.** While HREADY=0 the slave is in IDLE and accepts nothing; it keeps HREADYOUT=1.
- **cfg_wait_n changes** during a data phase do not affect the transfer in flight.
- **Wait count of 2^WAIT_W-1** is legal and gives the maximum stall; there is no wrap or overflow.

## Test plan
1. Reset mid-wait: NONSEQ write with cfg_wait_n=5, assert HRESET in the 2nd wait cycle -> outputs return to reset values asynchronously; mem_wr never asserts.
2. Zero-wait INCR4 write, DATA_W=32, addresses 0x10/0x14/0x18/0x1C, data 0xA0..0xA3 -> four consecutive mem_wr cycles with mem_wstrb=0xF and matching addresses/data; HREADYOUT stays 1.
3. Read with cfg_wait_n=3, mem_rdata=0xDEADBEEF -> HREADYOUT is 0 for 3 cycles, then 1 with HRDATA=0xDEADBEEF and mem_rd=1 for that cycle only.
4. SEQ_WAIT=0, cfg_wait_n=2, INCR4 read -> NONSEQ beat takes 3 cycles; each SEQ beat takes 1 cycle; 6 cycles in total.
5. Write to HADDR=MEM_BYTES, then a misaligned halfword at 0x3 -> each gets the ERR1/ERR2 sequence (HRESP=1, HREADYOUT 0 then 1); mem_wr stays 0; the next legal NONSEQ is accepted on the ERR2 edge.
6. DATA_W=64 byte write at 0x5 -> mem_wstrb=0x20; halfword write at 0x6 -> mem_wstrb=0xC0; BUSY inserted mid-burst -> OKAY, zero-wait, no memory strobe.

Source files
------------

// File: rtl/ahb3lite_mem_slave_p.sv
// AHB-Lite memory slave with pipelined address/data phases, programmable
// wait states, byte-lane strobes and a two-cycle ERROR response. Drives a
// single-port memory macro whose read data is combinational in mem_addr.
module ahb3lite_mem_slave_p #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned WAIT_W    = 4,
  parameter int unsigned SEQ_WAIT  = 1
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSEL,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [2:0]          HBURST,
  input  logic                HREADY,
  input  logic [DATA_W-1:0]   HWDATA,
  output logic [DATA_W-1:0]   HRDATA,
  output logic                HREADYOUT,
  output logic                HRESP,
  input  logic [WAIT_W-1:0]   cfg_wait_n,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(NB);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  localparam logic [1:0] TR_SEQ = 2'b11;

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;

  logic              accept;
  logic [7:0]        xfer_bytes;
  logic              out_of_range;
  logic              too_big;
  logic              misalign;
  logic              illegal;
  logic [WAIT_W-1:0] wait_sel;

  int unsigned       lane;
  int unsigned       nbytes;
  logic [NB-1:0]     strb_lane;

  logic              unused_hburst;

  // HBURST carries no behaviour; fold it so it is visibly consumed.
  always_comb begin
    unused_hburst = ^HBURST;
  end

  // Address-phase decode: acceptance, legality and the wait count to latch.
  always_comb begin
    accept       = HSEL & HREADY & HTRANS[1];
    xfer_bytes   = 8'd1 << HSIZE;
    out_of_range = (64'(HADDR) >= 64'(MEM_BYTES));
    too_big      = (xfer_bytes > 8'(NB));
    misalign     = |(HADDR[6:0] & (xfer_bytes[6:0] - 7'd1));
    illegal      = out_of_range | too_big | misalign;
    if ((HTRANS == TR_SEQ) && (SEQ_WAIT == 0)) begin
      wait_sel = '0;
    end else begin
      wait_sel = cfg_wait_n;
    end
  end

  // Next-state logic. Acceptance is only evaluated in the ready states
  // (IDLE, DATA, ERR2); that is what gives address/data pipelining.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= WAIT_W'(1)) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - WAIT_W'(1);
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept) begin
          addr_d  = HADDR;
          write_d = HWRITE;
          size_d  = HSIZE;
          if (illegal) begin
            state_d = ST_ERR1;
            cnt_d   = '0;
          end else if (wait_sel != '0) begin
            state_d = ST_WAIT;
            cnt_d   = wait_sel;
          end else begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and latched address-phase registers; reset discards any pending transfer.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Byte-lane mask: 2^size contiguous lanes starting at the low address bits.
  always_comb begin
    lane      = 32'(addr_q[LANE_W-1:0]);
    nbytes    = 32'd1 << size_q;
    strb_lane = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if ((i >= lane) && (i < lane + nbytes)) begin
        strb_lane[i] = 1'b1;
      end
    end
  end

  // Bus response and memory strobes, all decoded from the current state.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wstrb = '0;
    mem_wdata = '0;
    mem_addr  = addr_q;
    case (state_q)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: begin
        HRESP     = 1'b1;
      end
      ST_DATA: begin
        mem_rd    = ~write_q;
        mem_wr    = write_q;
        mem_wstrb = strb_lane;
        mem_wdata = HWDATA;
        if (!write_q) begin
          HRDATA = mem_rdata;
        end
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb3lite_mem_slave_p.sv
// Bench for ahb3lite_mem_slave_p: a 32-bit instance (SEQ beats waited) and a
// 64-bit instance (SEQ beats zero-wait) share one AHB bus; HREADY is the AND
// of both HREADYOUTs, with an override to model another slave stalling.
module tb_ahb3lite_mem_slave_p;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BY = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel_a, hsel_b;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hready, hready_lo;
  logic [63:0] hwdata;
  logic [3:0]  wait_n;
  logic [31:0] rdata_a;
  logic [63:0] rdata_b;

  logic [31:0] a_hrdata, a_maddr, a_mwd;
  logic        a_hro, a_hresp, a_mrd, a_mwr;
  logic [3:0]  a_strb;
  logic [63:0] b_hrdata, b_mwd;
  logic [31:0] b_maddr;
  logic        b_hro, b_hresp, b_mrd, b_mwr;
  logic [7:0]  b_strb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign hready = ~hready_lo & a_hro & b_hro;

  ahb3lite_mem_slave_p #(.DATA_W(32), .ADDR_W(32), .MEM_BYTES(4096), .WAIT_W(4), .SEQ_WAIT(1)) u_a (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel_a), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HREADY(hready),
    .HWDATA(hwdata[31:0]), .HRDATA(a_hrdata), .HREADYOUT(a_hro), .HRESP(a_hresp),
    .cfg_wait_n(wait_n), .mem_addr(a_maddr), .mem_rd(a_mrd), .mem_wr(a_mwr),
    .mem_wstrb(a_strb), .mem_wdata(a_mwd), .mem_rdata(rdata_a)
  );

  ahb3lite_mem_slave_p #(.DATA_W(64), .ADDR_W(32), .MEM_BYTES(4096), .WAIT_W(4), .SEQ_WAIT(0)) u_b (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel_b), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HREADY(hready),
    .HWDATA(hwdata), .HRDATA(b_hrdata), .HREADYOUT(b_hro), .HRESP(b_hresp),
    .cfg_wait_n(wait_n), .mem_addr(b_maddr), .mem_rd(b_mrd), .mem_wr(b_mwr),
    .mem_wstrb(b_strb), .mem_wdata(b_mwd), .mem_rdata(rdata_b)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  tr;
    logic [31:0] ad;
    logic        wr;
    logic [2:0]  sz;
    logic [63:0] wd;
    logic [63:0] rd;
    logic [3:0]  wn;
    logic        hro;
    logic        rsp;
    logic        mrd;
    logic        mwr;
    logic [7:0]  stb;
    logic [31:0] mad;
    logic [63:0] mwd;
    logic [63:0] hrd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic sel, input logic [1:0] tr, input logic [31:0] ad,
                             input logic wr, input logic [2:0] sz, input logic [63:0] wd,
                             input logic [63:0] rd, input logic [3:0] wn,
                             input logic hro, input logic rsp, input logic mrd, input logic mwr,
                             input logic [7:0] stb, input logic [31:0] mad,
                             input logic [63:0] mwd, input logic [63:0] hrd);
    vec_t r;
    r.sel = sel; r.tr = tr; r.ad = ad; r.wr = wr; r.sz = sz; r.wd = wd; r.rd = rd; r.wn = wn;
    r.hro = hro; r.rsp = rsp; r.mrd = mrd; r.mwr = mwr; r.stb = stb; r.mad = mad;
    r.mwd = mwd; r.hrd = hrd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic sa, input logic sb, input logic [1:0] tr, input logic [31:0] ad,
                     input logic wr, input logic [2:0] sz, input logic [63:0] wd,
                     input logic [3:0] wn);
    hsel_a = sa; hsel_b = sb; htrans = tr; haddr = ad; hwrite = wr; hsize = sz;
    hwdata = wd; wait_n = wn;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // One vector per clock: drive 1 after the edge, compare 4 after the edge.
  task automatic run_table(input bit use_b, input string pfx);
    logic        o_hro, o_rsp, o_mrd, o_mwr;
    logic [7:0]  o_stb;
    logic [31:0] o_mad;
    logic [63:0] o_mwd, o_hrd;
    for (int i = 0; i < tbl.size(); i++) begin
      drv(use_b ? 1'b0 : tbl[i].sel, use_b ? tbl[i].sel : 1'b0, tbl[i].tr, tbl[i].ad,
          tbl[i].wr, tbl[i].sz, tbl[i].wd, tbl[i].wn);
      rdata_a = tbl[i].rd[31:0];
      rdata_b = tbl[i].rd;
      #3;
      if (use_b) begin
        o_hro = b_hro; o_rsp = b_hresp; o_mrd = b_mrd; o_mwr = b_mwr;
        o_stb = b_strb; o_mad = b_maddr; o_mwd = b_mwd; o_hrd = b_hrdata;
      end else begin
        o_hro = a_hro; o_rsp = a_hresp; o_mrd = a_mrd; o_mwr = a_mwr;
        o_stb = {4'h0, a_strb}; o_mad = a_maddr; o_mwd = {32'h0, a_mwd}; o_hrd = {32'h0, a_hrdata};
      end
      chk($sformatf("%s[%0d].hreadyout", pfx, i), {63'h0, o_hro}, {63'h0, tbl[i].hro});
      chk($sformatf("%s[%0d].hresp", pfx, i), {63'h0, o_rsp}, {63'h0, tbl[i].rsp});
      chk($sformatf("%s[%0d].mem_rd", pfx, i), {63'h0, o_mrd}, {63'h0, tbl[i].mrd});
      chk($sformatf("%s[%0d].mem_wr", pfx, i), {63'h0, o_mwr}, {63'h0, tbl[i].mwr});
      chk($sformatf("%s[%0d].mem_wstrb", pfx, i), {56'h0, o_stb}, {56'h0, tbl[i].stb});
      chk($sformatf("%s[%0d].mem_addr", pfx, i), {32'h0, o_mad}, {32'h0, tbl[i].mad});
      chk($sformatf("%s[%0d].mem_wdata", pfx, i), o_mwd, tbl[i].mwd);
      chk($sformatf("%s[%0d].hrdata", pfx, i), o_hrd, tbl[i].hrd);
      next_cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int last_rd;
    logic [7:0] e_hro;
    logic [7:0] e_rd;
    int beat;

    hready_lo = 1'b0;
    hburst    = 3'b001;
    rdata_a   = 32'h1357_9BDF;
    rdata_b   = 64'h1357_9BDF_2468_ACE0;
    drv(1'b0, 1'b0, ID, 32'h0, 1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0);

    // Reset values, with nonzero bus inputs present.
    #12;
    chk("rst.a_hreadyout", {63'h0, a_hro}, 64'h1);
    chk("rst.a_hresp", {63'h0, a_hresp}, 64'h0);
    chk("rst.a_hrdata", {32'h0, a_hrdata}, 64'h0);
    chk("rst.a_mem_rd", {63'h0, a_mrd}, 64'h0);
    chk("rst.a_mem_wr", {63'h0, a_mwr}, 64'h0);
    chk("rst.a_mem_wstrb", {60'h0, a_strb}, 64'h0);
    chk("rst.a_mem_wdata", {32'h0, a_mwd}, 64'h0);
    chk("rst.a_mem_addr", {32'h0, a_maddr}, 64'h0);
    chk("rst.b_hreadyout", {63'h0, b_hro}, 64'h1);
    chk("rst.b_mem_wdata", b_mwd, 64'h0);
    chk("rst.b_hrdata", b_hrdata, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 32-bit slave: zero-wait INCR4 write, waited read, errors, lanes, BUSY/HSEL=0.
    hburst = 3'b011;
    tbl.delete();
    tbl.push_back(v(1, NS, 'h10,   1, 2, 0,     0, 0,   1, 0, 0, 0, 'h0, 'h0,  0,     0));
    tbl.push_back(v(1, SQ, 'h14,   1, 2, 'hA0,  0, 0,   1, 0, 0, 1, 'hF, 'h10, 'hA0,  0));
    tbl.push_back(v(1, SQ, 'h18,   1, 2, 'hA1,  0, 0,   1, 0, 0, 1, 'hF, 'h14, 'hA1,  0));
    tbl.push_back(v(1, SQ, 'h1C,   1, 2, 'hA2,  0, 0,   1, 0, 0, 1, 'hF, 'h18, 'hA2,  0));
    tbl.push_back(v(1, ID, 'h0,    0, 2, 'hA3,  0, 0,   1, 0, 0, 1, 'hF, 'h1C, 'hA3,  0));
    tbl.push_back(v(1, NS, 'h20,   0, 2, 'h55,  0, 3,   1, 0, 0, 0, 'h0, 'h1C, 0,     0));
    tbl.push_back(v(1, ID, 'h0,    0, 2, 'h55,  'hDEADBEEF, 7,   0, 0, 0, 0, 'h0, 'h20, 0, 0));
    tbl.push_back(v(1, ID, 'h0,    0, 2, 'h55,  'hDEADBEEF, 7,   0, 0, 0, 0, 'h0, 'h20, 0, 0));
    tbl.push_back(v(1, ID, 'h0,    0, 2, 'h55,  'hDEADBEEF, 7,   0, 0, 0, 0, 'h0, 'h20, 0, 0));
    tbl.push_back(v(1, NS, 'h1000, 1, 2, 0,     'hDEADBEEF, 5,   1, 0, 1, 0, 'hF, 'h20, 0, 'hDEADBEEF));
    tbl.push_back(v(1, NS, 'h3,    1, 1, 'h77,  0, 0,   0, 1, 0, 0, 'h0, 'h1000, 0,   0));
    tbl.push_back(v(1, NS, 'h3,    1, 1, 'h77,  0, 0,   1, 1, 0, 0, 'h0, 'h1000, 0,   0));
    tbl.push_back(v(1, NS, 'h8,    1, 2, 'h77,  0, 0,   0, 1, 0, 0, 'h0, 'h3,  0,     0));
    tbl.push_back(v(1, NS, 'h8,    1, 2, 'h77,  0, 0,   1, 1, 0, 0, 'h0, 'h3,  0,     0));
    tbl.push_back(v(1, ID, 'h0,    0, 2, 'h12345678, 0, 0,   1, 0, 0, 1, 'hF, 'h8, 'h12345678, 0));
    tbl.push_back(v(0, NS, 'h4,    1, 2, 0,     0, 0,   1, 0, 0, 0, 'h0, 'h8,  0,     0));
    tbl.push_back(v(1, NS, 'h2,    1, 0, 0,     0, 0,   1, 0, 0, 0, 'h0, 'h8,  0,     0));
    tbl.push_back(v(1, NS, 'h6,    0, 1, 'h00AA0000, 0, 0,   1, 0, 0, 1, 'h4, 'h2, 'h00AA0000, 0));
    tbl.push_back(v(1, BY, 'h8,    0, 1, 0,     'hCAFEF00D, 0,   1, 0, 1, 0, 'hC, 'h6, 0, 'hCAFEF00D));
    tbl.push_back(v(1, ID, 'h0,    0, 0, 0,     'hCAFEF00D, 0,   1, 0, 0, 0, 'h0, 'h6, 0, 0));
    tbl.push_back(v(1, NS, 'h4,    1, 3, 0,     0, 0,   1, 0, 0, 0, 'h0, 'h6,  0,     0));
    tbl.push_back(v(1, ID, 'h0,    0, 0, 0,     0, 0,   0, 1, 0, 0, 'h0, 'h4,  0,     0));
    tbl.push_back(v(1, ID, 'h0,    0, 0, 0,     0, 0,   1, 1, 0, 0, 'h0, 'h4,  0,     0));
    tbl.push_back(v(1, ID, 'h0,    0, 0, 0,     0, 0,   1, 0, 0, 0, 'h0, 'h4,  0,     0));
    run_table(1'b0, "a32");

    // Another slave holds HREADY low: nothing is accepted, HREADYOUT stays high.
    hready_lo = 1'b1;
    drv(1'b1, 1'b0, NS, 32'h30, 1'b1, 3'd2, 64'h0, 4'd0);
    #3;
    chk("hrdylo.hreadyout", {63'h0, a_hro}, 64'h1);
    next_cyc();
    #3;
    chk("hrdylo.mem_wr", {63'h0, a_mwr}, 64'h0);
    chk("hrdylo.mem_addr", {32'h0, a_maddr}, 64'h4);
    chk("hrdylo.hreadyout2", {63'h0, a_hro}, 64'h1);
    next_cyc();
    hready_lo = 1'b0;
    drv(1'b1, 1'b0, ID, 32'h0, 1'b0, 3'd2, 64'h0, 4'd0);
    #3;
    chk("hrdylo.mem_wr_after", {63'h0, a_mwr}, 64'h0);
    next_cyc();

    // Maximum wait count: 15 stall cycles, then one DATA cycle.
    rdata_a = 32'h0BAD_F00D;
    drv(1'b1, 1'b0, NS, 32'h0, 1'b0, 3'd2, 64'h0, 4'd15);
    next_cyc();
    drv(1'b1, 1'b0, ID, 32'h0, 1'b0, 3'd2, 64'h0, 4'd0);
    n = 0;
    while (a_hro == 1'b0 && n < 40) begin
      n++;
      next_cyc();
    end
    #2;
    chk("maxwait.stall_cycles", 64'(n), 64'd15);
    chk("maxwait.mem_rd", {63'h0, a_mrd}, 64'h1);
    chk("maxwait.hrdata", {32'h0, a_hrdata}, 64'h0BAD_F00D);
    next_cyc();
    chk("maxwait.mem_rd_after", {63'h0, a_mrd}, 64'h0);

    // Reset asserted in the 2nd wait cycle of a write with cfg_wait_n=5.
    drv(1'b1, 1'b0, NS, 32'h24, 1'b1, 3'd2, 64'h99, 4'd5);
    next_cyc();
    drv(1'b1, 1'b0, ID, 32'h0, 1'b0, 3'd2, 64'h99, 4'd5);
    #3;
    chk("rstwait.wait1_hreadyout", {63'h0, a_hro}, 64'h0);
    next_cyc();
    chk("rstwait.wait2_mem_addr", {32'h0, a_maddr}, 64'h24);
    #1;
    rst = 1'b1;
    #1;
    chk("rstwait.hreadyout", {63'h0, a_hro}, 64'h1);
    chk("rstwait.hresp", {63'h0, a_hresp}, 64'h0);
    chk("rstwait.mem_addr", {32'h0, a_maddr}, 64'h0);
    chk("rstwait.mem_wr", {63'h0, a_mwr}, 64'h0);
    chk("rstwait.mem_wdata", {32'h0, a_mwd}, 64'h0);
    chk("rstwait.mem_wstrb", {60'h0, a_strb}, 64'h0);
    next_cyc();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #3;
      chk($sformatf("rstwait.post[%0d].mem_wr", k), {63'h0, a_mwr}, 64'h0);
      chk($sformatf("rstwait.post[%0d].hreadyout", k), {63'h0, a_hro}, 64'h1);
      next_cyc();
    end

    // 64-bit slave (SEQ beats zero-wait): lanes, BUSY mid-burst, errors.
    hburst = 3'b001;
    tbl.delete();
    tbl.push_back(v(1, NS, 'h5,  1, 0, 0, 0, 0,   1, 0, 0, 0, 'h00, 'h0, 0, 0));
    tbl.push_back(v(1, NS, 'h6,  1, 1, 'h0000_5500_0000_0000, 0, 0,   1, 0, 0, 1, 'h20, 'h5, 'h0000_5500_0000_0000, 0));
    tbl.push_back(v(1, BY, 'h8,  1, 1, 'hBEEF_0000_0000_0000, 0, 0,   1, 0, 0, 1, 'hC0, 'h6, 'hBEEF_0000_0000_0000, 0));
    tbl.push_back(v(1, SQ, 'h8,  1, 1, 0, 0, 3,   1, 0, 0, 0, 'h00, 'h6, 0, 0));
    tbl.push_back(v(1, ID, 'h0,  0, 0, 'h1234, 0, 0,   1, 0, 0, 1, 'h03, 'h8, 'h1234, 0));
    tbl.push_back(v(1, NS, 'h4,  1, 3, 0, 0, 0,   1, 0, 0, 0, 'h00, 'h8, 0, 0));
    tbl.push_back(v(1, NS, 'h10, 1, 3, 0, 0, 0,   0, 1, 0, 0, 'h00, 'h4, 0, 0));
    tbl.push_back(v(1, NS, 'h10, 1, 3, 0, 0, 0,   1, 1, 0, 0, 'h00, 'h4, 0, 0));
    tbl.push_back(v(1, ID, 'h0,  0, 0, 'hFFEEDDCC_BBAA9988, 0, 0,   1, 0, 0, 1, 'hFF, 'h10, 'hFFEEDDCC_BBAA9988, 0));
    tbl.push_back(v(1, NS, 'h0,  0, 4, 0, 0, 0,   1, 0, 0, 0, 'h00, 'h10, 0, 0));
    tbl.push_back(v(1, ID, 'h0,  0, 0, 0, 0, 0,   0, 1, 0, 0, 'h00, 'h0, 0, 0));
    tbl.push_back(v(1, ID, 'h0,  0, 0, 0, 0, 0,   1, 1, 0, 0, 'h00, 'h0, 0, 0));
    tbl.push_back(v(1, ID, 'h0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 'h00, 'h0, 0, 0));
    run_table(1'b1, "b64");

    // INCR4 read on the 64-bit slave, cfg_wait_n=2: NONSEQ 3 cycles, SEQ 1 each.
    hburst  = 3'b011;
    e_hro   = 8'b1111_1001;
    e_rd    = 8'b0111_1000;
    beat    = 0;
    last_rd = -1;
    for (int c = 0; c < 8; c++) begin
      if (beat < 4) begin
        drv(1'b0, 1'b1, (beat == 0) ? NS : SQ, 32'h40 + 32'(beat) * 32'd8, 1'b0, 3'd3, 64'h0, 4'd2);
      end else begin
        drv(1'b0, 1'b1, ID, 32'h0, 1'b0, 3'd3, 64'h0, 4'd2);
      end
      rdata_b = {32'hC0DE_0000, 32'(c)};
      #3;
      chk($sformatf("incr4[%0d].hreadyout", c), {63'h0, b_hro}, {63'h0, e_hro[c]});
      chk($sformatf("incr4[%0d].mem_rd", c), {63'h0, b_mrd}, {63'h0, e_rd[c]});
      if (e_rd[c]) begin
        chk($sformatf("incr4[%0d].mem_addr", c), {32'h0, b_maddr}, 64'h40 + 64'(c - 3) * 64'd8);
        chk($sformatf("incr4[%0d].hrdata", c), b_hrdata, {32'hC0DE_0000, 32'(c)});
      end
      if (b_mrd) begin
        last_rd = c;
      end
      if (hready && beat < 4) begin
        beat++;
      end
      next_cyc();
    end
    chk("incr4.total_cycles", 64'(last_rd), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
